// File: rtl/scan_test_ctrl.sv
// Scan-test sequencer for the scan-inserted s27 benchmark: streams patterns into the
// scan chain, issues one capture per pattern and checks captured PO and unloaded responses.
module scan_test_ctrl #(
  parameter int CHAIN_LEN = 3,
  parameter int NUM_PI    = 4,
  parameter int NUM_PO    = 1,
  parameter int CNT_W     = 8
) (
  input  logic                 CK,
  input  logic                 RST,
  input  logic                 START,
  input  logic                 PAT_VALID,
  output logic                 PAT_READY,
  input  logic [CHAIN_LEN-1:0] PAT_SI,
  input  logic [NUM_PI-1:0]    PAT_PI,
  input  logic [NUM_PO-1:0]    EXP_PO,
  input  logic [CHAIN_LEN-1:0] EXP_SO,
  input  logic                 PAT_LAST,
  output logic                 DUT_CKE,
  output logic                 SE,
  output logic                 SI,
  input  logic                 SO,
  output logic [NUM_PI-1:0]    PI,
  input  logic [NUM_PO-1:0]    PO,
  output logic                 BUSY,
  output logic                 DONE,
  output logic                 FAIL,
  output logic [CNT_W-1:0]     FAIL_CNT,
  output logic [CNT_W-1:0]     PAT_CNT
);

  typedef enum logic [2:0] {IDLE, WAIT_PAT, LOAD, CAPTURE, FLUSH, DONE_S} state_t;

  localparam int IDX_W = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHAIN_LEN - 1);

  state_t state, next_state;

  logic [IDX_W-1:0]     idx;
  logic [CHAIN_LEN-1:0] si_sh;
  logic [CHAIN_LEN-1:0] exp_so_q;
  logic [NUM_PO-1:0]    exp_po_q;
  logic                 last_q;
  logic [CHAIN_LEN-1:0] pend_so;
  logic                 pending;
  logic                 pend_bad;

  logic se_d, cke_d, ready_d, busy_d, done_d;
  logic session_start, accept, last_shift, unload, so_miss, resolve, pat_bad;

  assign session_start = START && (state == IDLE || state == DONE_S);
  assign accept        = (state == WAIT_PAT) && PAT_VALID;
  assign last_shift    = (idx == LAST_IDX);
  assign unload        = (state == LOAD || state == FLUSH) && pending;
  assign so_miss       = unload && (SO != pend_so[CHAIN_LEN-1]);
  assign resolve       = unload && last_shift;
  // The verdict folds in the current edge's SO bit so a last-bit miss still counts.
  assign pat_bad       = pend_bad | so_miss;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values, independent of process ordering.
  always_ff @(posedge CK) begin
    if (RST) state <= IDLE;
    else     state <= next_state;
  end

  // NOTE: default assignment first so no path leaves next_state unassigned (no latch).
  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (START)      next_state = WAIT_PAT;
      WAIT_PAT: if (PAT_VALID)  next_state = LOAD;
      LOAD:     if (last_shift) next_state = CAPTURE;
      CAPTURE:  next_state = last_q ? FLUSH : WAIT_PAT;
      FLUSH:    if (last_shift) next_state = DONE_S;
      DONE_S:   if (START)      next_state = WAIT_PAT;
      default:  next_state = IDLE;
    endcase
  end

  // Control outputs are decoded from next_state and registered, so they switch only at CK.
  always_comb begin
    se_d    = 1'b0;
    cke_d   = 1'b0;
    ready_d = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (next_state)
      WAIT_PAT: begin ready_d = 1'b1; busy_d = 1'b1; end
      LOAD:     begin se_d = 1'b1; cke_d = 1'b1; busy_d = 1'b1; end
      CAPTURE:  begin cke_d = 1'b1; busy_d = 1'b1; end
      FLUSH:    begin se_d = 1'b1; cke_d = 1'b1; busy_d = 1'b1; end
      DONE_S:   done_d = 1'b1;
      default:  ;
    endcase
  end

  // NOTE: pattern/response data registers carry no reset; they are always written
  // before use and pending/state qualify them.
  always_ff @(posedge CK) begin
    if (accept) begin
      si_sh    <= PAT_SI << 1;
      exp_so_q <= EXP_SO;
      exp_po_q <= EXP_PO;
      last_q   <= PAT_LAST;
    end else if (state == LOAD && !last_shift) begin
      si_sh <= si_sh << 1;
    end
    if (state == CAPTURE)
      pend_so <= exp_so_q;
    else if (unload)
      pend_so <= pend_so << 1;
  end

  always_ff @(posedge CK) begin
    if (RST) begin
      SE        <= 1'b0;
      SI        <= 1'b0;
      PI        <= '0;
      DUT_CKE   <= 1'b0;
      PAT_READY <= 1'b0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      FAIL      <= 1'b0;
      FAIL_CNT  <= '0;
      PAT_CNT   <= '0;
      pending   <= 1'b0;
      pend_bad  <= 1'b0;
      idx       <= '0;
    end else begin
      SE        <= se_d;
      DUT_CKE   <= cke_d;
      PAT_READY <= ready_d;
      BUSY      <= busy_d;
      DONE      <= done_d;

      if (session_start) begin
        FAIL     <= 1'b0;
        FAIL_CNT <= '0;
        PAT_CNT  <= '0;
        pending  <= 1'b0;
        pend_bad <= 1'b0;
      end

      if (accept) begin
        PI  <= PAT_PI;
        SI  <= PAT_SI[CHAIN_LEN-1];
        idx <= '0;
      end

      if (state == LOAD || state == FLUSH)
        idx <= last_shift ? '0 : idx + 1'b1;

      if (state == LOAD && !last_shift)
        SI <= si_sh[CHAIN_LEN-1];
      else if (state == CAPTURE && last_q)
        SI <= 1'b0;

      if (unload)
        pend_bad <= pat_bad;

      if (resolve) begin
        pending <= 1'b0;
        if (pat_bad) begin
          FAIL <= 1'b1;
          if (FAIL_CNT != '1) FAIL_CNT <= FAIL_CNT + 1'b1;
        end
      end

      if (state == CAPTURE) begin
        pending  <= 1'b1;
        pend_bad <= (PO != exp_po_q);
        if (PAT_CNT != '1) PAT_CNT <= PAT_CNT + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_scan_test_ctrl.sv
// Bench for scan_test_ctrl: drives a 3-flop scan stub and checks session results against
// a pattern-level model (response = PI[2:0], PO = ^PI, verdict per pattern).
module tb_scan_test_ctrl;
  localparam int CL  = 3;
  localparam int NPI = 4;
  localparam int NPO = 1;
  localparam int CW  = 8;

  logic           CK = 1'b0;
  logic           RST = 1'b1;
  logic           START = 1'b0;
  logic           PAT_VALID = 1'b0;
  logic           PAT_LAST = 1'b0;
  logic [CL-1:0]  PAT_SI = '0;
  logic [CL-1:0]  EXP_SO = '0;
  logic [NPI-1:0] PAT_PI = '0;
  logic [NPO-1:0] EXP_PO = '0;
  logic           PAT_READY, DUT_CKE, SE, SI, SO, BUSY, DONE, FAIL;
  logic [NPI-1:0] PI;
  logic [NPO-1:0] PO;
  logic [CW-1:0]  FAIL_CNT, PAT_CNT;

  logic [CL-1:0]  chain = '0;
  int n_cmp = 0;
  int n_bad = 0;
  int exp_pats = 0;
  int exp_fails = 0;

  scan_test_ctrl #(.CHAIN_LEN(CL), .NUM_PI(NPI), .NUM_PO(NPO), .CNT_W(CW)) dut (
    .CK(CK), .RST(RST), .START(START), .PAT_VALID(PAT_VALID), .PAT_READY(PAT_READY),
    .PAT_SI(PAT_SI), .PAT_PI(PAT_PI), .EXP_PO(EXP_PO), .EXP_SO(EXP_SO), .PAT_LAST(PAT_LAST),
    .DUT_CKE(DUT_CKE), .SE(SE), .SI(SI), .SO(SO), .PI(PI), .PO(PO),
    .BUSY(BUSY), .DONE(DONE), .FAIL(FAIL), .FAIL_CNT(FAIL_CNT), .PAT_CNT(PAT_CNT)
  );

  always #5 CK = ~CK;

  // Scan-inserted stub with a gated clock; bit CL-1 is nearest SO.
  always @(posedge CK)
    if (DUT_CKE) chain <= SE ? {chain[CL-2:0], SI} : PI[CL-1:0];
  assign SO = chain[CL-1];
  assign PO = NPO'(^PI);

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (got timeout, expected $finish)");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit pat_fails(input logic [NPI-1:0] pi, input logic [NPO-1:0] epo,
                                   input logic [CL-1:0] eso);
    return (epo != NPO'(^pi)) || (eso != pi[CL-1:0]);
  endfunction

  function automatic int sat(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_se"}, SE, 0);
    check({tag, "_si"}, SI, 0);
    check({tag, "_pi"}, PI, 0);
    check({tag, "_cke"}, DUT_CKE, 0);
    check({tag, "_ready"}, PAT_READY, 0);
    check({tag, "_busy"}, BUSY, 0);
    check({tag, "_done"}, DONE, 0);
    check({tag, "_fail"}, FAIL, 0);
    check({tag, "_fcnt"}, FAIL_CNT, 0);
    check({tag, "_pcnt"}, PAT_CNT, 0);
  endtask

  task automatic start_session();
    START = 1'b1;
    @(negedge CK);
    START = 1'b0;
    check("start_busy", BUSY, 1);
    check("start_done", DONE, 0);
    check("start_fail", FAIL, 0);
    check("start_pcnt", PAT_CNT, 0);
    check("start_fcnt", FAIL_CNT, 0);
    exp_pats  = 0;
    exp_fails = 0;
  endtask

  task automatic present(input logic [CL-1:0] si, input logic [NPI-1:0] pi,
                         input logic [NPO-1:0] epo, input logic [CL-1:0] eso, input bit last);
    PAT_SI = si; PAT_PI = pi; EXP_PO = epo; EXP_SO = eso; PAT_LAST = last;
    PAT_VALID = 1'b1;
    @(negedge CK);
    PAT_VALID = 1'b0;
    exp_pats++;
    if (pat_fails(pi, epo, eso)) exp_fails++;
  endtask

  // Waits for PAT_READY, idles `gap` cycles checking the DUT is frozen, then hands over.
  task automatic send_pattern(input logic [CL-1:0] si, input logic [NPI-1:0] pi,
                              input logic [NPO-1:0] epo, input logic [CL-1:0] eso,
                              input bit last, input int gap, input bit glitch);
    int  n;
    logic so0;
    n = 0;
    while (!PAT_READY && n < 50) begin
      @(negedge CK);
      n++;
    end
    check("ready_wait", PAT_READY, 1);
    so0 = SO;
    for (int i = 0; i < gap; i++) begin
      START = glitch && (i == 0);
      @(negedge CK);
      check("gap_cke", DUT_CKE, 0);
      check("gap_so", SO, so0);
      check("gap_ready", PAT_READY, 1);
    end
    START = 1'b0;
    present(si, pi, epo, eso, last);
  endtask

  task automatic finish_session();
    int n;
    n = 0;
    while (!DONE && n < 50) begin
      @(negedge CK);
      n++;
    end
    check("done", DONE, 1);
    check("busy_end", BUSY, 0);
    check("idle_cke", DUT_CKE, 0);
    check("idle_se", SE, 0);
    check("pat_cnt", PAT_CNT, sat(exp_pats));
    check("fail_cnt", FAIL_CNT, sat(exp_fails));
    check("fail_flag", FAIL, (exp_fails > 0) ? 1 : 0);
  endtask

  // One-pattern session with cycle-by-cycle checks of the scan waveform.
  task automatic single_detail(input logic [CL-1:0] si, input logic [NPI-1:0] pi,
                               input logic [NPO-1:0] epo, input logic [CL-1:0] eso);
    logic [CL-1:0] resp;
    resp = pi[CL-1:0];
    start_session();
    check("ready", PAT_READY, 1);
    present(si, pi, epo, eso, 1'b1);
    for (int i = 0; i < CL; i++) begin
      check("load_se", SE, 1);
      check("load_si", SI, si[CL-1-i]);
      check("load_cke", DUT_CKE, 1);
      check("load_pi", PI, pi);
      @(negedge CK);
    end
    check("cap_se", SE, 0);
    check("cap_cke", DUT_CKE, 1);
    @(negedge CK);
    for (int i = 0; i < CL; i++) begin
      check("flush_se", SE, 1);
      check("flush_si", SI, 0);
      check("flush_so", SO, resp[CL-1-i]);
      @(negedge CK);
    end
    finish_session();
  endtask

  task automatic random_session(input int n, input int bad_pct, input int max_gap, input bit glitch);
    logic [NPI-1:0] pi;
    logic [CL-1:0]  si, eso;
    logic [NPO-1:0] epo;
    int gap;
    start_session();
    for (int k = 0; k < n; k++) begin
      pi  = NPI'($urandom);
      si  = CL'($urandom);
      epo = NPO'(^pi);
      eso = pi[CL-1:0];
      if ($urandom_range(0, 99) < bad_pct) begin
        if ($urandom_range(0, 1) == 0) epo = ~epo;
        else eso = eso ^ CL'($urandom_range(1, 7));
      end
      gap = $urandom_range(0, max_gap);
      send_pattern(si, pi, epo, eso, k == n - 1, (glitch && k == 1) ? 2 : gap, glitch && k == 1);
    end
    finish_session();
  endtask

  initial begin
    logic [NPI-1:0] pi;

    // Power-on reset, then a mid-session abort.
    repeat (2) @(negedge CK);
    RST = 1'b0;
    check_reset_outputs("por");
    start_session();
    present(3'b110, 4'b0101, 1'b0, 3'b101, 1'b0);
    @(negedge CK);
    RST = 1'b1;
    @(negedge CK);
    check_reset_outputs("abort1");
    @(negedge CK);
    RST = 1'b0;
    check_reset_outputs("abort2");
    start_session();
    present(3'b001, 4'b0110, 1'b0, 3'b110, 1'b1);
    finish_session();

    // Directed single patterns: passing, bad SO, bad PO, both bad.
    single_detail(3'b101, 4'b0011, 1'b0, 3'b011);
    single_detail(3'b101, 4'b0011, 1'b0, 3'b010);
    single_detail(3'b101, 4'b0011, 1'b1, 3'b011);
    single_detail(3'b101, 4'b0011, 1'b1, 3'b000);

    // Three passing patterns with 2-cycle stalls between them.
    start_session();
    send_pattern(3'b111, 4'b1010, 1'b0, 3'b010, 1'b0, 2, 1'b0);
    send_pattern(3'b000, 4'b0111, 1'b1, 3'b111, 1'b0, 2, 1'b0);
    send_pattern(3'b010, 4'b1100, 1'b0, 3'b100, 1'b1, 2, 1'b0);
    finish_session();

    // START pulsed while busy must be ignored.
    random_session(5, 0, 2, 1'b1);
    random_session(6, 50, 2, 1'b1);

    // Randomized mixed sessions.
    for (int s = 0; s < 6; s++)
      random_session($urandom_range(1, 10), 40, 2, 1'b0);

    // 300 failing patterns: both counters saturate.
    start_session();
    for (int k = 0; k < 300; k++) begin
      pi = NPI'($urandom);
      send_pattern(CL'($urandom), pi, NPO'(^pi), ~pi[CL-1:0], k == 299, 0, 1'b0);
    end
    finish_session();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
